// File: rtl/ahb_lite_initiator.sv
// Valid/ready command port to pipelined AHB-Lite NONSEQ/SINGLE transfers with one response per command.
// Zero-wait latency is accept edge + 3 to rsp_valid. Commands are refused while HREADY is low or an ERROR reissue is pending.
module ahb_lite_initiator #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic        NONSEC     = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic                  HNONSEC,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  if (!(DATA_WIDTH == 8   || DATA_WIDTH == 16  || DATA_WIDTH == 32  || DATA_WIDTH == 64 ||
        DATA_WIDTH == 128 || DATA_WIDTH == 256 || DATA_WIDTH == 512 || DATA_WIDTH == 1024)) begin : g_bad_width
    $fatal(1, "ahb_lite_initiator: illegal DATA_WIDTH %0d", DATA_WIDTH);
  end

  logic                  ap_valid_q;
  logic [ADDR_WIDTH-1:0] ap_addr_q;
  logic                  ap_write_q;
  logic [2:0]            ap_size_q;
  logic [DATA_WIDTH-1:0] ap_wdata_q;
  logic                  ap_hold_q;
  logic                  dp_valid_q;
  logic                  dp_write_q;
  logic [DATA_WIDTH-1:0] dp_wdata_q;
  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  done_d;

  // ap_hold masks the address phase during the second ERROR cycle so the pending command is reissued.
  assign HTRANS    = (ap_valid_q && !ap_hold_q) ? 2'b10 : 2'b00;
  assign HADDR     = ap_addr_q;
  assign HWRITE    = ap_write_q;
  assign HSIZE     = ap_size_q;
  assign HBURST    = 3'b000;
  assign HNONSEC   = NONSEC;
  assign HWDATA    = (dp_valid_q && dp_write_q) ? dp_wdata_q : '0;
  assign cmd_ready = HREADY & ~ap_hold_q;
  assign done_d    = HREADY & dp_valid_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      ap_addr_q   <= '0;
      ap_write_q  <= 1'b0;
      ap_size_q   <= 3'b000;
      ap_wdata_q  <= '0;
      ap_hold_q   <= 1'b0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= done_d;
      rsp_write_q <= done_d & dp_write_q;
      rsp_err_q   <= done_d & HRESP;
      rsp_rdata_q <= (done_d && !dp_write_q) ? HRDATA : '0;

      if (!HREADY) begin
        if (dp_valid_q && HRESP) ap_hold_q <= 1'b1;
      end else if (ap_hold_q) begin
        ap_hold_q  <= 1'b0;
        dp_valid_q <= 1'b0;
      end else begin
        dp_valid_q <= ap_valid_q;
        dp_write_q <= ap_write_q;
        dp_wdata_q <= ap_wdata_q;
        ap_valid_q <= cmd_valid;
        if (cmd_valid) begin
          ap_addr_q  <= cmd_addr;
          ap_write_q <= cmd_write;
          ap_size_q  <= cmd_size;
          ap_wdata_q <= cmd_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Bench for ahb_lite_initiator: reactive AHB-Lite subordinate with wait/error injection and an in-order response scoreboard.
module tb_ahb_lite_initiator;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_SIZE = $clog2(DW / 8);

  logic          HCLK, HRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HNONSEC, HREADY, HRESP;
  logic [2:0]    HSIZE, HBURST;
  logic [DW-1:0] HWDATA, HRDATA;

  ahb_lite_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NONSEC(1'b0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HNONSEC(HNONSEC), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_bad = 0;
  int rsp_cnt = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    return DW'(((a >> 2) + 1) * 32'h11);
  endfunction

  // Subordinate model: one data phase, optional wait states or two-cycle ERROR for a selected address.
  logic [AW-1:0] err_addr, wait_addr;
  int            wait_n;
  logic          sub_vld, sub_wr, sub_err, sub_err2;
  logic [AW-1:0] sub_addr;
  int            sub_cnt;

  assign HREADY = !sub_vld ? 1'b1 : (sub_cnt != 0) ? 1'b0 : sub_err ? sub_err2 : 1'b1;
  assign HRESP  = sub_vld && (sub_cnt == 0) && sub_err;
  assign HRDATA = (sub_vld && !sub_wr) ? rd_fn(sub_addr) : '0;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sub_vld <= 1'b0; sub_wr <= 1'b0; sub_err <= 1'b0; sub_err2 <= 1'b0;
      sub_addr <= '0; sub_cnt <= 0;
    end else if (HREADY) begin
      sub_vld  <= (HTRANS == 2'b10);
      sub_addr <= HADDR;
      sub_wr   <= HWRITE;
      sub_cnt  <= (HADDR == wait_addr) ? wait_n : 0;
      sub_err  <= (HADDR == err_addr);
      sub_err2 <= 1'b0;
    end else if (sub_cnt != 0) begin
      sub_cnt <= sub_cnt - 1;
    end else begin
      sub_err2 <= 1'b1;
    end
  end

  always @(posedge HCLK) begin
    if (HRESETn && cmd_valid && cmd_ready) begin
      assert (int'(cmd_size) <= MAX_SIZE) else $error("illegal cmd_size %0d", cmd_size);
      assert ((cmd_addr & ((AW'(1) << cmd_size) - 1)) == 0) else $error("misaligned cmd_addr 0x%0h", cmd_addr);
    end
  end

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t scb[$];

  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      rsp_cnt++;
      if (scb.size() == 0) begin
        chk_eq("rsp_extra", rsp_valid, 1'b0);
      end else begin
        exp_t e;
        e = scb.pop_front();
        chk_eq("rsp_write", rsp_write, e.wr);
        chk_eq("rsp_err", rsp_err, e.err);
        chk_eq("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic w, input logic [2:0] sz,
                      input logic [DW-1:0] wd, input logic e, output int cyc);
    logic acc;
    cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_size = sz; cmd_wdata = wd;
    cyc = 0;
    acc = 1'b0;
    while (!acc && cyc < 20) begin
      @(negedge HCLK);
      acc = cmd_ready;
      tick();
      cyc++;
    end
    chk_eq("accept", acc, 1'b1);
    if (acc) scb.push_back('{wr: w, err: e, rdata: (w ? '0 : rd_fn(a))});
    cmd_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int c;
    int rsp_before;
    HRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = '0; cmd_wdata = '0;
    err_addr = '1; wait_addr = '1; wait_n = 0;
    #12;
    chk_eq("rst_htrans", HTRANS, 2'b00);
    chk_eq("rst_haddr", HADDR, 0);
    chk_eq("rst_hwrite", HWRITE, 0);
    chk_eq("rst_hsize", HSIZE, 0);
    chk_eq("rst_hwdata", HWDATA, 0);
    chk_eq("rst_hburst", HBURST, 0);
    chk_eq("rst_hnonsec", HNONSEC, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_cmd_ready", cmd_ready, 1);
    tick();
    HRESETn = 1'b1;
    repeat (2) tick();

    // single write, zero wait
    send(32'h10, 1'b1, 3'd2, 32'hA5A5_0001, 1'b0, c);
    chk_eq("wr_htrans", HTRANS, 2'b10);
    chk_eq("wr_haddr", HADDR, 32'h10);
    chk_eq("wr_hwrite", HWRITE, 1);
    chk_eq("wr_hsize", HSIZE, 3'd2);
    tick();
    chk_eq("wr_hwdata", HWDATA, 32'hA5A5_0001);
    tick();
    chk_eq("wr_rsp_valid", rsp_valid, 1);
    repeat (3) tick();

    // back-to-back reads
    for (int i = 0; i < 3; i++) begin
      send(32'(i * 4), 1'b0, 3'd2, '0, 1'b0, c);
      chk_eq("b2b_accept_cycles", c, 1);
      chk_eq("b2b_htrans", HTRANS, 2'b10);
    end
    for (int i = 0; i < 3; i++) begin
      chk_eq("b2b_rsp_valid", rsp_valid, 1);
      tick();
    end
    chk_eq("b2b_rsp_end", rsp_valid, 0);
    repeat (3) tick();

    // wait states on a write with a read pending
    wait_addr = 32'h40; wait_n = 2;
    send(32'h40, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b0, c);
    send(32'h44, 1'b0, 3'd2, '0, 1'b0, c);
    for (int i = 0; i < 3; i++) begin
      chk_eq("ws_haddr", HADDR, 32'h44);
      chk_eq("ws_htrans", HTRANS, 2'b10);
      chk_eq("ws_hwdata", HWDATA, 32'hDEAD_BEEF);
      chk_eq("ws_cmd_ready", cmd_ready, (i < 2) ? 1'b0 : 1'b1);
      tick();
    end
    wait_addr = '1; wait_n = 0;
    repeat (4) tick();

    // ERROR on a write with a read in its address phase
    err_addr = 32'h20;
    send(32'h20, 1'b1, 3'd2, 32'h0000_1234, 1'b1, c);
    send(32'h24, 1'b0, 3'd2, '0, 1'b0, c);
    chk_eq("err_first_htrans", HTRANS, 2'b10);
    tick();
    chk_eq("err_second_htrans", HTRANS, 2'b00);
    chk_eq("err_second_cmd_ready", cmd_ready, 0);
    tick();
    chk_eq("err_rsp_valid", rsp_valid, 1);
    chk_eq("err_reissue_htrans", HTRANS, 2'b10);
    chk_eq("err_reissue_haddr", HADDR, 32'h24);
    err_addr = '1;
    repeat (4) tick();

    // byte write
    send(32'h3, 1'b1, 3'd0, 32'hCC00_0000, 1'b0, c);
    chk_eq("byte_hsize", HSIZE, 3'd0);
    chk_eq("byte_haddr", HADDR, 32'h3);
    tick();
    chk_eq("byte_hwdata", HWDATA, 32'hCC00_0000);
    repeat (4) tick();
    chk_eq("drain_before_reset", scb.size(), 0);

    // reset mid-transfer
    send(32'h8, 1'b0, 3'd2, '0, 1'b0, c);
    tick();
    HRESETn = 1'b0;
    #1;
    chk_eq("rst_mid_htrans", HTRANS, 2'b00);
    chk_eq("rst_mid_rsp_valid", rsp_valid, 0);
    chk_eq("rst_mid_haddr", HADDR, 0);
    scb.delete();
    rsp_before = rsp_cnt;
    tick();
    HRESETn = 1'b1;
    repeat (6) tick();
    chk_eq("rst_mid_no_rsp", rsp_cnt, rsp_before);
    chk_eq("scb_empty", scb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_lite_initiator.md
# ahb_lite_initiator

AHB-Lite manager-side adapter: accepts single-beat read/write commands on a valid/ready command port and issues them as pipelined AHB-Lite NONSEQ/SINGLE transfers, returning one response per command. It is the initiator counterpart of the register-interface AHB-Lite subordinate adapter. It lets DMA engines, debug bridges and test sequencers drive AHB-Lite register blocks without implementing AHB pipelining or the two-cycle ERROR protocol.

## Interface
- ADDR_WIDTH, 32, address width of HADDR and cmd_addr.
- DATA_WIDTH, 32, data bus width; legal values are 8, 16, 32, 64, 128, 256, 512 and 1024. Any other value triggers $fatal at elaboration.
- NONSEC, 1'b0, constant value driven on HNONSEC.
- HCLK  in  1  clock; every register is clocked on its rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted at this edge when both valid and ready are high.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  3  HSIZE encoding.
- cmd_wdata  in  DATA_WIDTH  write data, already placed on the correct byte lanes for the address.
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure.
- rsp_write  out  1  direction of the completed transfer.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  the subordinate returned ERROR.
- HADDR  out  ADDR_WIDTH  address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  transfer size.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HNONSEC  out  1  constant NONSEC.
- HWDATA  out  DATA_WIDTH  write data.
- HRDATA  in  DATA_WIDTH  read data.
- HREADY  in  1  combined bus ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

## Operation
- **Address-phase slot** (ap_valid, ap_addr, ap_write, ap_size, ap_wdata) drives HADDR, HWRITE and HSIZE from registers.
  - HTRANS = NONSEQ when ap_valid is set and ap_hold is clear; otherwise IDLE.
- **Data-phase slot** (dp_valid, dp_write, dp_wdata) drives HWDATA = dp_wdata while dp_valid and dp_write are set; otherwise HWDATA = 0.
- **Slot advance** (HREADY = 1 at an edge, ap_hold clear):
  - The address slot moves into the data slot: dp_valid <= ap_valid & (HTRANS == NONSEQ).
  - If cmd_valid and cmd_ready are both high, the address slot loads the command; otherwise ap_valid <= 0.
- cmd_ready = HREADY & ~ap_hold. Commands are accepted only on edges where the bus advances.
- **Wait states** (HREADY = 0): both slots hold. HADDR, HTRANS, HWRITE, HSIZE and HWDATA stay stable.
- **Completion**: an edge with HREADY = 1 and dp_valid set completes the data phase. The next cycle has:
  - rsp_valid = 1 and rsp_write = dp_write.
  - rsp_err = HRESP as sampled at that edge.
  - rsp_rdata = HRDATA for a read, 0 for a write.
- **ERROR handling** (reissue policy):
  - An edge with dp_valid, HRESP = 1 and HREADY = 0 is the first ERROR cycle. At that edge ap_hold <= 1, so HTRANS = IDLE during the second ERROR cycle. A pending address phase is cancelled on the bus but kept in the address slot.
  - The edge where HREADY = 1 completes the errored transfer with rsp_err = 1. At that edge ap_hold <= 0 and dp_valid <= 0, and the address slot is not advanced.
  - The held command is therefore re-presented as NONSEQ in the next cycle and completes normally.
- Responses are returned in command order, exactly one per accepted command.
- **Command legality is the requester's responsibility**:
  - cmd_size ≤ log2(DATA_WIDTH/8).
  - cmd_addr aligned to the transfer size.
  - Verification checks both with assertions; the RTL does not handle violations.

## Timing
- **Reset values**:
  - HTRANS = 00; HADDR, HWRITE, HSIZE, HWDATA = 0.
  - cmd_ready = HREADY (ap_hold = 0).
  - rsp_valid, rsp_write, rsp_err, rsp_rdata = 0.
  - All slots are empty.
- **Zero-wait latency**: command accepted at edge E → NONSEQ in cycle E..E+1 → data phase in cycle E+1..E+2 → rsp_valid high in cycle E+2..E+3.
- **Throughput**: one transfer per cycle with a zero-wait subordinate.
- Each wait state adds one cycle of latency to every transfer in flight.
- **Reset mid-transfer**: all slots clear and outputs return to reset values immediately (asynchronously). No response is produced for commands in flight.
- **Simultaneous events**:
  - Completion, advance and command accept at the same edge are all legal.
  - A first ERROR cycle blocks any accept at that edge, because HREADY = 0.

## Test plan
- **Single write, zero wait**: write addr 0x10, size 2, wdata 0xA5A5_0001, accepted at edge E.
  - HTRANS = 10 and HADDR = 0x10 in cycle E+1.
  - HWDATA = 0xA5A5_0001 in cycle E+2.
  - rsp_valid = 1, rsp_write = 1, rsp_err = 0 in cycle E+3.
- **Back-to-back reads**: reads of 0x0, 0x4, 0x8 with HRDATA = 0x11, 0x22, 0x33.
  - HTRANS = NONSEQ for 3 consecutive cycles and cmd_ready stays 1.
  - Three consecutive rsp pulses with rsp_rdata = 0x11, 0x22, 0x33.
- **Wait states**: write 0x40 with 2 wait states while a read of 0x44 is pending.
  - HADDR = 0x44, HTRANS = 10 and HWDATA are stable for 3 cycles.
  - cmd_ready = 0 for 2 cycles.
  - Write response precedes read response.
- **ERROR with reissue**: write 0x20 receives ERROR while a read of 0x24 is in its address phase.
  - HTRANS = 00 during the second ERROR cycle.
  - Write response has rsp_err = 1.
  - HADDR = 0x24 NONSEQ is reissued the next cycle and its response has rsp_err = 0.
- **Byte write**: size 0, addr 0x3, wdata 0xCC00_0000 → HSIZE = 000, HADDR = 0x3, HWDATA = 0xCC00_0000.
- **Reset mid-transfer**: drop HRESETn while a read is in its data phase → HTRANS = 00 and rsp_valid = 0 immediately, and no response is produced after reset release.
